// File: rtl/div_req_queue.sv
// ---------------------------------------------------------------------------
// div_req_queue
//
// Operand-issue and result-capture stage around a combinational divider.
// Operand pairs are accepted with a valid/ready handshake into a small FIFO.
// An FSM pops the FIFO head and handles it in one of two ways:
//   - Non-zero divisor: drives the divider, waits SETTLE cycles, then
//     registers its quotient/remainder.
//   - Zero divisor: never reaches the divider. It produces an immediate
//     divide-by-zero result instead.
// Results are then presented downstream with valid/ready.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready             operand handshake
//   in_dividend/in_divisor        operand pair
//   div_dividend/div_divisor      registered operands to the divider
//                                 (divisor never 0)
//   div_quotient/div_remainder    combinational results from the divider
//   out_valid/out_ready           result handshake
//   out_quotient/out_remainder    registered result
//   out_dbz                       result came from a zero divisor
//   count                         FIFO occupancy
// ---------------------------------------------------------------------------
module div_req_queue #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_dividend,
    input  logic [WIDTH-1:0]         in_divisor,
    output logic [WIDTH-1:0]         div_dividend,
    output logic [WIDTH-1:0]         div_divisor,
    input  logic [WIDTH-1:0]         div_quotient,
    input  logic [WIDTH-1:0]         div_remainder,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_quotient,
    output logic [WIDTH-1:0]         out_remainder,
    output logic                     out_dbz,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(SETTLE + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [WIDTH-1:0] memDividend [DEPTH];
    logic [WIDTH-1:0] memDivisor  [DEPTH];

    logic [AW-1:0]    wrPtr_q, rdPtr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [1:0]       state_q, state_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [WIDTH-1:0] divDividend_q, divDividend_d;
    logic [WIDTH-1:0] divDivisor_q, divDivisor_d;
    logic [WIDTH-1:0] outQuotient_q, outQuotient_d;
    logic [WIDTH-1:0] outRemainder_q, outRemainder_d;
    logic             outDbz_q, outDbz_d;
    logic             outValid_q, outValid_d;

    logic             push, pop;
    logic [WIDTH-1:0] headDividend, headDivisor;

    assign in_ready     = (count_q != CW'(DEPTH));
    assign push         = in_valid && in_ready;
    assign headDividend = memDividend[rdPtr_q];
    assign headDivisor  = memDivisor[rdPtr_q];

    // FIFO storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            memDividend[wrPtr_q] <= in_dividend;
            memDivisor[wrPtr_q]  <= in_divisor;
        end
    end

    // Occupancy: a simultaneous push and pop cancel out.
    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (!push && pop)
            count_d = count_q - CW'(1);
    end

    // Issue/capture FSM. A pop happens from IDLE, or from HOLD on the edge
    // the current result is accepted, so back-to-back requests issue
    // without an idle cycle. A zero divisor bypasses the divider and leaves
    // the divider operand registers untouched, so div_divisor stays non-zero.
    always_comb begin
        state_d        = state_q;
        settle_d       = settle_q;
        divDividend_d  = divDividend_q;
        divDivisor_d   = divDivisor_q;
        outQuotient_d  = outQuotient_q;
        outRemainder_d = outRemainder_q;
        outDbz_d       = outDbz_q;
        outValid_d     = outValid_q;
        pop            = 1'b0;

        case (state_q)
            IDLE: ;
            DRIVE: begin
                settle_d = settle_q - SW'(1);
                if (settle_q == SW'(1)) begin
                    outQuotient_d  = div_quotient;
                    outRemainder_d = div_remainder;
                    outDbz_d       = 1'b0;
                    outValid_d     = 1'b1;
                    state_d        = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    outValid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_q == IDLE || (state_q == HOLD && out_ready)) && count_q != '0) begin
            pop = 1'b1;
            if (headDivisor != '0) begin
                divDividend_d = headDividend;
                divDivisor_d  = headDivisor;
                settle_d      = SW'(SETTLE);
                state_d       = DRIVE;
            end else begin
                outQuotient_d  = '1;
                outRemainder_d = headDividend;
                outDbz_d       = 1'b1;
                outValid_d     = 1'b1;
                state_d        = HOLD;
            end
        end
    end

    // State registers; reset drops queued entries and any in-flight result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q        <= '0;
            rdPtr_q        <= '0;
            count_q        <= '0;
            state_q        <= IDLE;
            settle_q       <= '0;
            divDividend_q  <= '0;
            divDivisor_q   <= WIDTH'(1);
            outQuotient_q  <= '0;
            outRemainder_q <= '0;
            outDbz_q       <= 1'b0;
            outValid_q     <= 1'b0;
        end else begin
            if (push)
                wrPtr_q <= wrPtr_q + AW'(1);
            if (pop)
                rdPtr_q <= rdPtr_q + AW'(1);
            count_q        <= count_d;
            state_q        <= state_d;
            settle_q       <= settle_d;
            divDividend_q  <= divDividend_d;
            divDivisor_q   <= divDivisor_d;
            outQuotient_q  <= outQuotient_d;
            outRemainder_q <= outRemainder_d;
            outDbz_q       <= outDbz_d;
            outValid_q     <= outValid_d;
        end
    end

    assign div_dividend  = divDividend_q;
    assign div_divisor   = divDivisor_q;
    assign out_quotient  = outQuotient_q;
    assign out_remainder = outRemainder_q;
    assign out_dbz       = outDbz_q;
    assign out_valid     = outValid_q;
    assign count         = count_q;

endmodule

// File: tb/tb_div_req_queue.sv
// ---------------------------------------------------------------------------
// tb_div_req_queue
//
// Self-checking bench for div_req_queue.
// - The main instance uses SETTLE=1.
// - A second instance with SETTLE=3 checks the longer capture latency.
// - Each instance is wrapped around a behavioural combinational divider.
// - Expected results are queued when an operand handshake occurs and
//   compared when a result handshake occurs.
// ---------------------------------------------------------------------------
module tb_div_req_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, out_dbz;
    logic [3:0] in_dividend, in_divisor, div_dividend, div_divisor;
    logic [3:0] div_quotient, div_remainder, out_quotient, out_remainder;
    logic [2:0] count;

    logic       in_valid3, in_ready3, out_valid3, out_ready3, out_dbz3;
    logic [3:0] in_dividend3, in_divisor3, div_dividend3, div_divisor3;
    logic [3:0] div_quotient3, div_remainder3, out_quotient3, out_remainder3;
    logic [2:0] count3;

    int assertCount = 0;
    int failCount   = 0;
    int peakCount   = 0;
    logic [8:0] expQ [$];

    always #5 clk = ~clk;

    // Behavioural combinational dividers
    assign div_quotient   = (div_divisor == 4'd0) ? 4'd0 : div_dividend / div_divisor;
    assign div_remainder  = (div_divisor == 4'd0) ? 4'd0 : div_dividend % div_divisor;
    assign div_quotient3  = (div_divisor3 == 4'd0) ? 4'd0 : div_dividend3 / div_divisor3;
    assign div_remainder3 = (div_divisor3 == 4'd0) ? 4'd0 : div_dividend3 % div_divisor3;

    div_req_queue #(.WIDTH(4), .DEPTH(4), .SETTLE(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quotient(out_quotient), .out_remainder(out_remainder),
        .out_dbz(out_dbz), .count(count)
    );

    div_req_queue #(.WIDTH(4), .DEPTH(4), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3),
        .in_dividend(in_dividend3), .in_divisor(in_divisor3),
        .div_dividend(div_dividend3), .div_divisor(div_divisor3),
        .div_quotient(div_quotient3), .div_remainder(div_remainder3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .out_quotient(out_quotient3), .out_remainder(out_remainder3),
        .out_dbz(out_dbz3), .count(count3)
    );

    // Reference result: {dbz, quotient, remainder}
    function automatic logic [8:0] model(input logic [3:0] a, input logic [3:0] b);
        if (b == 4'd0)
            return {1'b1, 4'hF, a};
        return {1'b0, a / b, a % b};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
        in_valid    = 1'b1;
        in_dividend = a;
        in_divisor  = b;
    endtask

    // One clock cycle on the main instance:
    // - Before the edge, record operand handshakes and score result handshakes.
    // - After the edge, drop in_valid if it was accepted.
    task automatic clockCycle();
        logic       hs;
        logic [8:0] e;
        if (in_valid && in_ready)
            expQ.push_back(model(in_dividend, in_divisor));
        if (out_valid && out_ready) begin
            checkOutput("result_expected", {31'd0, expQ.size() != 0}, 32'd1);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput("out_quotient", {28'd0, out_quotient}, {28'd0, e[7:4]});
                checkOutput("out_remainder", {28'd0, out_remainder}, {28'd0, e[3:0]});
                checkOutput("out_dbz", {31'd0, out_dbz}, {31'd0, e[8]});
            end
        end
        hs = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (hs)
            in_valid = 1'b0;
        if (int'(count) > peakCount)
            peakCount = int'(count);
        checkOutput("div_divisor_nonzero", {31'd0, div_divisor != 4'd0}, 32'd1);
        checkOutput("div_divisor3_nonzero", {31'd0, div_divisor3 != 4'd0}, 32'd1);
    endtask

    // Run until nothing is pending or outstanding, with a cycle bound.
    task automatic drain(input int maxCycles);
        for (int i = 0; i < maxCycles; i++) begin
            if (expQ.size() == 0 && !in_valid && !out_valid && count == 3'd0)
                break;
            clockCycle();
        end
        checkOutput("drain_complete", {31'd0, expQ.size() == 0 && !in_valid}, 32'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 1'b0; in_dividend = 4'd0; in_divisor = 4'd0; out_ready = 1'b1;
        in_valid3 = 1'b0; in_dividend3 = 4'd0; in_divisor3 = 4'd0; out_ready3 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] reset state");
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_quotient", {28'd0, out_quotient}, 32'd0);
        checkOutput("rst_out_remainder", {28'd0, out_remainder}, 32'd0);
        checkOutput("rst_out_dbz", {31'd0, out_dbz}, 32'd0);
        checkOutput("rst_count", {29'd0, count}, 32'd0);
        checkOutput("rst_div_dividend", {28'd0, div_dividend}, 32'd0);
        checkOutput("rst_div_divisor", {28'd0, div_divisor}, 32'd1);
        rst = 1'b0;

        $display("[TB] single request 13/4");
        applyStimulus(4'd13, 4'd4);
        clockCycle();
        checkOutput("t1_count_after_push", {29'd0, count}, 32'd1);
        checkOutput("t1_valid_after_push", {31'd0, out_valid}, 32'd0);
        clockCycle();
        checkOutput("t1_div_divisor", {28'd0, div_divisor}, 32'd4);
        checkOutput("t1_div_dividend", {28'd0, div_dividend}, 32'd13);
        checkOutput("t1_valid_after_pop", {31'd0, out_valid}, 32'd0);
        clockCycle();
        checkOutput("t1_valid_latency", {31'd0, out_valid}, 32'd1);
        clockCycle();
        checkOutput("t1_valid_cleared", {31'd0, out_valid}, 32'd0);

        $display("[TB] divide by zero 7/0");
        applyStimulus(4'd7, 4'd0);
        clockCycle();
        checkOutput("t2_valid_after_push", {31'd0, out_valid}, 32'd0);
        clockCycle();
        checkOutput("t2_valid_latency", {31'd0, out_valid}, 32'd1);
        checkOutput("t2_dbz", {31'd0, out_dbz}, 32'd1);
        checkOutput("t2_div_divisor_kept", {28'd0, div_divisor}, 32'd4);
        clockCycle();
        checkOutput("t2_valid_cleared", {31'd0, out_valid}, 32'd0);

        $display("[TB] back-to-back requests");
        peakCount = 0;
        applyStimulus(4'd0, 4'd5);  clockCycle();
        applyStimulus(4'd4, 4'd9);  clockCycle();
        applyStimulus(4'd15, 4'd1); clockCycle();
        drain(40);
        checkOutput("t3_peak_count", peakCount, 32'd2);
        checkOutput("t3_final_count", {29'd0, count}, 32'd0);

        $display("[TB] backpressure with full FIFO");
        out_ready = 1'b0;
        applyStimulus(4'd12, 4'd5); clockCycle();
        applyStimulus(4'd9, 4'd3);  clockCycle();
        applyStimulus(4'd8, 4'd0);  clockCycle();
        applyStimulus(4'd14, 4'd4); clockCycle();
        applyStimulus(4'd6, 4'd7);  clockCycle();
        checkOutput("t4_count_full", {29'd0, count}, 32'd4);
        checkOutput("t4_in_ready_low", {31'd0, in_ready}, 32'd0);
        checkOutput("t4_held_valid", {31'd0, out_valid}, 32'd1);
        applyStimulus(4'd10, 4'd3);
        for (int i = 0; i < 3; i++) begin
            clockCycle();
            checkOutput("t4_stall_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("t4_stall_count", {29'd0, count}, 32'd4);
            checkOutput("t4_stall_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("t4_stall_quotient", {28'd0, out_quotient}, 32'd2);
            checkOutput("t4_stall_remainder", {28'd0, out_remainder}, 32'd2);
        end
        out_ready = 1'b1;
        drain(80);

        $display("[TB] reset during DRIVE");
        out_ready = 1'b0;
        applyStimulus(4'd1, 4'd1); clockCycle();
        applyStimulus(4'd9, 4'd2); clockCycle();
        applyStimulus(4'd3, 4'd1); clockCycle();
        applyStimulus(4'd5, 4'd2); clockCycle();
        out_ready = 1'b1;
        clockCycle();
        checkOutput("t5_pre_count", {29'd0, count}, 32'd2);
        checkOutput("t5_pre_div_divisor", {28'd0, div_divisor}, 32'd2);
        checkOutput("t5_pre_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("t5_rst_count", {29'd0, count}, 32'd0);
        checkOutput("t5_rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("t5_rst_div_divisor", {28'd0, div_divisor}, 32'd1);
        expQ.delete();
        #1;
        rst = 1'b0;
        applyStimulus(4'd9, 4'd2); clockCycle();
        drain(20);

        $display("[TB] SETTLE=3 instance 11/3");
        in_valid3 = 1'b1; in_dividend3 = 4'd11; in_divisor3 = 4'd3;
        checkOutput("t6_in_ready3", {31'd0, in_ready3}, 32'd1);
        clockCycle();
        in_valid3 = 1'b0;
        n = 0;
        while (!out_valid3 && n < 20) begin
            clockCycle();
            n++;
        end
        checkOutput("t6_latency_cycles", n, 32'd4);
        checkOutput("t6_quotient", {28'd0, out_quotient3}, 32'd3);
        checkOutput("t6_remainder", {28'd0, out_remainder3}, 32'd2);
        checkOutput("t6_dbz", {31'd0, out_dbz3}, 32'd0);
        clockCycle();
        checkOutput("t6_valid_cleared", {31'd0, out_valid3}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
